multi_intr_generator: RTL and testbench
=======================================

Name: multi_intr_generator

Overview:
- Multi-channel successor to the single-channel read-interrupt pulse generator in the ZYNQ7PS top.
- Turns PL-side event requests into PS interrupt lines, one per channel.
- Rising edges of requests are queued in per-channel saturating counters, so no event is lost while a pulse is in flight.
- Each channel runs either timed pulses with runtime-programmable high/low widths, or a level interrupt held until the PS acknowledges it.

Parameters:
- NUM_CH, 4: number of independent interrupt channels.
- CNT_WIDTH, 15: width of the high/low duration counters and configuration inputs.
- PEND_WIDTH, 4: width of each channel's pending-event counter; it saturates at 2^PEND_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start_intr  in  NUM_CH  per-channel event request; only rising edges count.
- high_cycles  in  CNT_WIDTH  timed-mode assert width in cycles; 0 is treated as 1.
- low_cycles  in  CNT_WIDTH  mandatory deassert gap after each interrupt; 0 means no gap.
- ack_mode  in  NUM_CH  per channel: 0 = timed pulse, 1 = level until ack.
- intr_ack  in  NUM_CH  per-channel acknowledge; used only in ack mode.
- intr  out  NUM_CH  interrupt lines to the PS.
- pending  out  NUM_CH*PEND_WIDTH  pending counts; channel i occupies bits [i*PEND_WIDTH +: PEND_WIDTH].
- overflow  out  NUM_CH  sticky per-channel flag: an edge was dropped at saturation.
- busy  out  1  OR over all channels of (state != IDLE or pending != 0).

Behaviour:
- Reset, synchronous on rst_n low: every state = IDLE; counters, pending, overflow, intr and the edge-detect registers all = 0. Reset asserted mid-pulse drops intr at the next clock edge and discards queued events.
- Edge detect: start_q[i] registers start_intr[i]. An edge is start_intr[i] & ~start_q[i]. A level held high produces exactly one event.
- Pending update, per channel, each cycle:
  - +1 on edge, -1 on dequeue, unchanged when both occur in the same cycle.
  - An edge while pending is at max and with no dequeue that cycle: pending holds, overflow[i] is set.
  - overflow clears only on reset.
- Per-channel FSM states: IDLE, ASSERT, GAP.
- IDLE:
  - If pending != 0: dequeue; go to ASSERT; intr=1.
  - At this transition, latch hi_lat = max(high_cycles,1), lo_lat = low_cycles, mode_lat = ack_mode[i]. Configuration changes mid-pulse have no effect.
  - Otherwise intr=0 and cnt=0.
- ASSERT, timed mode:
  - intr stays 1 for exactly hi_lat cycles, counted with cnt from 1 up to hi_lat.
  - Then cnt=0 and intr=0, and the channel goes to GAP, or straight to IDLE if lo_lat==0.
- ASSERT, ack mode:
  - intr stays 1 until intr_ack[i] is sampled 1.
  - The next cycle intr=0, and the channel goes to GAP, or to IDLE if lo_lat==0.
  - intr_ack while the channel is not in ASSERT is ignored.
- GAP: intr=0 for exactly lo_lat cycles, then IDLE.
- Latency:
  - The first cycle start_intr is high is cycle t. The edge is counted into pending at the clock ending cycle t.
  - The IDLE transition occurs at the clock ending t+1, so intr is high from cycle t+2.
  - Back-to-back queued events: the next intr rises on the cycle after the channel returns to IDLE, i.e. at least one low cycle between pulses even with lo_lat==0.
- Channels are fully independent; there is no arbitration. Counters never wrap, because the compare is against the latched value.

Test Plan:
- Single timed pulse: high_cycles=3, low_cycles=2, one-cycle edge on ch0 at t → intr[0] high in cycles t+2..t+4, low in t+5..t+6, busy drops at t+7.
- Queueing: three edges on ch1 spaced two cycles apart, high=5, low=0 → three 5-cycle pulses separated by 1 low cycle; pending peaks at 2 and ends at 0.
- Saturation: PEND_WIDTH=2, 5 edges on ch2 while its first pulse is asserting (high=50) → pending sticks at 3, overflow[2]=1 and stays 1; exactly 4 pulses total.
- Ack mode: ack_mode[3]=1, edge, intr_ack pulsed 10 cycles after intr rises → intr[3] high exactly 11 cycles, then low_cycles gap; an early ack before the edge has no effect.
- Mid-pulse config change plus reset: high_cycles changed 8→2 during a pulse → that pulse is still 8 cycles; rst_n low mid-pulse → intr, pending and overflow are all 0 on the next edge.
- Simultaneous edge and dequeue, with high_cycles=0 → pending unchanged; pulses are 1 cycle wide.

Source files
------------

// File: rtl/multi_intr_generator.sv
// ---------------------------------------------------------------------------
// multi_intr_generator
//
// Multi-channel interrupt pulse generator. It turns PL-side event requests
// into PS interrupt lines, one line per channel. Each rising edge on a request
// input is stored in a saturating per-channel pending counter, so an event is
// not lost while a pulse is still running. Each channel produces either a
// timed pulse with programmable high/low widths, or a level interrupt that
// stays high until the PS acknowledges it.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   start_intr   [NUM_CH]     per-channel event request (rising edge counts)
//   high_cycles  [CNT_WIDTH]  timed-mode high width (0 behaves as 1)
//   low_cycles   [CNT_WIDTH]  deassert gap after each interrupt (0 = none)
//   ack_mode     [NUM_CH]     0 = timed pulse, 1 = level until intr_ack
//   intr_ack     [NUM_CH]     per-channel acknowledge (used in ack mode only)
//   intr         [NUM_CH]     interrupt lines to the PS
//   pending      [NUM_CH*PEND_WIDTH] pending counts, channel i at
//                             [i*PEND_WIDTH +: PEND_WIDTH]
//   overflow     [NUM_CH]     sticky flag: an edge was dropped at saturation
//   busy                      some channel is active or has events queued
// ---------------------------------------------------------------------------
module multi_intr_generator #(
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 15,
   parameter int PEND_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            start_intr,
   input  logic [CNT_WIDTH-1:0]         high_cycles,
   input  logic [CNT_WIDTH-1:0]         low_cycles,
   input  logic [NUM_CH-1:0]            ack_mode,
   input  logic [NUM_CH-1:0]            intr_ack,
   output logic [NUM_CH-1:0]            intr,
   output logic [NUM_CH*PEND_WIDTH-1:0] pending,
   output logic [NUM_CH-1:0]            overflow,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

   localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

   state_t                state     [NUM_CH];
   state_t                state_nxt [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt       [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt_nxt   [NUM_CH];
   logic [CNT_WIDTH-1:0]  hi_lat    [NUM_CH];
   logic [CNT_WIDTH-1:0]  lo_lat    [NUM_CH];
   logic [PEND_WIDTH-1:0] pend      [NUM_CH];
   logic [NUM_CH-1:0]     mode_lat;
   logic [NUM_CH-1:0]     start_q;
   logic [NUM_CH-1:0]     edge_det;
   logic [NUM_CH-1:0]     deq;
   logic [NUM_CH-1:0]     ovf;
   logic [CNT_WIDTH-1:0]  hi_eff;

   // A level held high yields a single event: only 0->1 transitions count.
   assign edge_det = start_intr & ~start_q;
   assign hi_eff   = (high_cycles == '0) ? CNT_ONE : high_cycles;
   assign overflow = ovf;

   // State register and per-channel counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         start_q <= start_intr;
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
      end
   end

   // Configuration is captured when a pulse is launched, so a change to the
   // inputs while a pulse is in flight only affects the next pulse.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (deq[i]) begin
            hi_lat[i]   <= hi_eff;
            lo_lat[i]   <= low_cycles;
            mode_lat[i] <= ack_mode[i];
         end
      end
   end

   // Pending counters: a simultaneous edge and dequeue cancel out, and an
   // edge that would exceed the maximum is dropped and flagged instead.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pend[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (edge_det[i] && !deq[i]) begin
               if (pend[i] == PEND_MAX) begin
                  ovf[i] <= 1'b1;
               end else begin
                  pend[i] <= pend[i] + PEND_WIDTH'(1);
               end
            end else if (deq[i] && !edge_det[i]) begin
               pend[i] <= pend[i] - PEND_WIDTH'(1);
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         deq[i]       = 1'b0;
         case (state[i])
            IDLE: begin
               cnt_nxt[i] = '0;
               if (pend[i] != '0) begin
                  deq[i]       = 1'b1;
                  state_nxt[i] = ASSERT;
                  // The first high cycle is cycle 1 of hi_lat.
                  cnt_nxt[i]   = CNT_ONE;
               end
            end
            ASSERT: begin
               if (mode_lat[i] ? intr_ack[i] : (cnt[i] == hi_lat[i])) begin
                  cnt_nxt[i]   = '0;
                  state_nxt[i] = (lo_lat[i] == '0) ? IDLE : GAP;
               end else if (!mode_lat[i]) begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            GAP: begin
               // GAP counts 0 .. lo_lat-1; lo_lat is non-zero here.
               if (cnt[i] == lo_lat[i] - CNT_ONE) begin
                  cnt_nxt[i]   = '0;
                  state_nxt[i] = IDLE;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            default: begin
               cnt_nxt[i]   = '0;
               state_nxt[i] = IDLE;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      intr    = '0;
      pending = '0;
      busy    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         intr[i] = (state[i] == ASSERT);
         pending[i*PEND_WIDTH +: PEND_WIDTH] = pend[i];
         busy = busy | (state[i] != IDLE) | (pend[i] != '0);
      end
   end

endmodule

// File: tb/tb_multi_intr_generator.sv
// ---------------------------------------------------------------------------
// tb_multi_intr_generator
//
// Randomized bench for multi_intr_generator. The reference model describes
// each channel by the window of cycles in which its interrupt is high and the
// cycle from which the channel is free again, plus an integer pending count.
// All outputs are compared every cycle on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multi_intr_generator;

   localparam int NCH  = 4;
   localparam int CW   = 15;
   localparam int PW   = 2;
   localparam int PMAX = (1 << PW) - 1;
   localparam int INF  = 32'h3fff_ffff;
   localparam int NCYC = 3200;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    start_intr;
   logic [CW-1:0]     high_cycles;
   logic [CW-1:0]     low_cycles;
   logic [NCH-1:0]    ack_mode;
   logic [NCH-1:0]    intr_ack;
   logic [NCH-1:0]    intr;
   logic [NCH*PW-1:0] pending;
   logic [NCH-1:0]    overflow;
   logic              busy;

   multi_intr_generator #(
      .NUM_CH     (NCH),
      .CNT_WIDTH  (CW),
      .PEND_WIDTH (PW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_intr  (start_intr),
      .high_cycles (high_cycles),
      .low_cycles  (low_cycles),
      .ack_mode    (ack_mode),
      .intr_ack    (intr_ack),
      .intr        (intr),
      .pending     (pending),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: one pulse window [hi_start, hi_end] and the first
   // cycle the channel can launch again (free_at).
   int m_pend    [NCH];
   bit m_ovf     [NCH];
   bit m_prev    [NCH];
   int m_hi_start[NCH];
   int m_hi_end  [NCH];
   int m_free_at [NCH];
   int m_lo      [NCH];
   bit m_mode    [NCH];
   int n_pulses  [NCH];
   bit saw_ovf;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_pend[i]     = 0;
         m_ovf[i]      = 1'b0;
         m_prev[i]     = 1'b0;
         m_hi_start[i] = 1;
         m_hi_end[i]   = 0;
         m_free_at[i]  = 0;
         m_lo[i]       = 0;
         m_mode[i]     = 1'b0;
      end
   endtask

   // Advance the model across the clock edge that ends cycle c.
   task automatic model_step(input int c);
      bit idle, deq, edg;
      int h;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         idle = (c >= m_free_at[i]);
         deq  = idle && (m_pend[i] > 0);
         if (!idle && m_mode[i] && m_hi_start[i] <= c && c <= m_hi_end[i]
             && intr_ack[i]) begin
            m_hi_end[i]  = c;
            m_free_at[i] = c + m_lo[i] + 1;
         end
         if (deq) begin
            h = (int'(high_cycles) == 0) ? 1 : int'(high_cycles);
            m_lo[i]       = int'(low_cycles);
            m_mode[i]     = ack_mode[i];
            m_hi_start[i] = c + 1;
            n_pulses[i]++;
            if (m_mode[i]) begin
               m_hi_end[i]  = INF;
               m_free_at[i] = INF;
            end else begin
               m_hi_end[i]  = c + h;
               m_free_at[i] = c + h + m_lo[i] + 1;
            end
         end
         edg = start_intr[i] && !m_prev[i];
         m_prev[i] = start_intr[i];
         if (edg && !deq) begin
            if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
            else m_pend[i]++;
         end else if (deq && !edg) begin
            m_pend[i]--;
         end
      end
   endtask

   task automatic compare_outputs(input int c);
      logic [NCH-1:0]    e_intr;
      logic [NCH*PW-1:0] e_pend;
      logic [NCH-1:0]    e_ovf;
      logic              e_busy;
      e_busy = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         e_intr[i] = (m_hi_start[i] <= c) && (c <= m_hi_end[i]);
         e_pend[i*PW +: PW] = PW'(m_pend[i]);
         e_ovf[i]  = m_ovf[i];
         e_busy    = e_busy | (c < m_free_at[i]) | (m_pend[i] != 0);
      end
      check("intr",     32'(intr),     32'(e_intr));
      check("pending",  32'(pending),  32'(e_pend));
      check("overflow", 32'(overflow), 32'(e_ovf));
      check("busy",     32'(busy),     32'(e_busy));
      if (overflow != '0) saw_ovf = 1'b1;
   endtask

   // Random inputs; the profile changes every 400 cycles to stress timed
   // pulses, saturation, zero widths and acknowledge mode in turn.
   task automatic drive_inputs(input int c);
      int prof;
      prof = (c / 400) % 4;
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NCH; i++) begin
         case (prof)
            0: start_intr[i] = ($urandom_range(0, 9) < 3);
            1: start_intr[i] = ($urandom_range(0, 1) == 1);
            2: start_intr[i] = ($urandom_range(0, 1) == 1);
            default: start_intr[i] = ($urandom_range(0, 9) < 2);
         endcase
         intr_ack[i] = ($urandom_range(0, 9) < ((prof == 3) ? 1 : 2));
      end
      case (prof)
         0: begin
            high_cycles = CW'($urandom_range(0, 5));
            low_cycles  = CW'($urandom_range(0, 3));
            if (c % 50 == 0) ack_mode = NCH'($urandom);
         end
         1: begin
            if (c % 60 == 0) high_cycles = CW'($urandom_range(30, 50));
            low_cycles = CW'($urandom_range(0, 2));
            ack_mode   = '0;
         end
         2: begin
            high_cycles = '0;
            low_cycles  = '0;
            ack_mode    = '0;
         end
         default: begin
            high_cycles = CW'($urandom_range(1, 4));
            low_cycles  = CW'($urandom_range(0, 4));
            ack_mode    = '1;
         end
      endcase
   endtask

   initial begin
      saw_ovf     = 1'b0;
      rst_n       = 1'b0;
      start_intr  = '0;
      high_cycles = CW'(3);
      low_cycles  = CW'(2);
      ack_mode    = '0;
      intr_ack    = '0;
      for (int i = 0; i < NCH; i++) n_pulses[i] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      for (int k = 0; k < NCYC; k++) begin
         @(negedge clk);
         compare_outputs(cyc);
         drive_inputs(cyc);
         model_step(cyc);
         cyc++;
      end
      // Final quiet drain: inputs idle, acknowledges held so ack-mode
      // channels finish, then everything must be empty.
      @(negedge clk);
      rst_n      = 1'b1;
      start_intr = '0;
      intr_ack   = '1;
      for (int k = 0; k < 200; k++) begin
         compare_outputs(cyc);
         model_step(cyc);
         cyc++;
         @(negedge clk);
      end
      check("drain_busy", 32'(busy), 32'(0));
      check("ovf_seen", 32'(saw_ovf), 32'(1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
